// File: rtl/led_pattern_gen.sv
// led_pattern_gen: parametrised LED pattern engine.
// A period counter produces a tick every (STEP_CYCLES >> speed) cycles.
// On each tick the LED frame either loads the first frame of a newly
// selected mode or advances the current pattern by one step.
// Both outputs are registered, so no input reaches an output combinationally.
module led_pattern_gen #(
  parameter int LED_W       = 8,
  parameter int STEP_CYCLES = 6_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step
);

  localparam int CNT_W = $clog2(STEP_CYCLES);

  localparam logic [LED_W-1:0] MSB_ONLY = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LSB_ONLY = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] ALL_ONES = {LED_W{1'b1}};
  localparam logic [LED_W-1:0] ALL_ZERO = {LED_W{1'b0}};

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  dir_t             dir_q, dir_d;
  logic             step_q, step_d;

  logic [31:0]      period_s;
  logic [31:0]      cnt_ext_s;
  logic             tick_s;

  // Step period for the current speed; >= lets a shrinking period tick at once.
  always_comb begin
    period_s  = 32'(STEP_CYCLES) >> speed;
    cnt_ext_s = 32'(cnt_q);
    if (!pause && (cnt_ext_s >= (period_s - 32'd1))) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Period counter: clear on tick, hold while paused, otherwise count up.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (!pause) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pattern engine: load the first frame of a new mode, or step the current one.
  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = tick_s;
    if (tick_s) begin
      if (mode != mode_q) begin
        mode_d = mode;
        case (mode)
          3'd0: led_d = MSB_ONLY;
          3'd1: led_d = LSB_ONLY;
          3'd2: led_d = ALL_ZERO;
          3'd3: led_d = ALL_ONES;
          3'd4: begin
            led_d = MSB_ONLY;
            dir_d = DIR_DOWN;
          end
          3'd5: led_d = ALL_ONES;
          default: led_d = led_q;  // freeze keeps the current frame
        endcase
      end else begin
        case (mode_q)
          3'd0: led_d = {led_q[0], led_q[LED_W-1:1]};
          3'd1: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          3'd2: begin
            if (led_q == ALL_ONES) begin
              led_d = ALL_ZERO;
            end else begin
              led_d = {led_q[LED_W-2:0], 1'b1};
            end
          end
          3'd3: begin
            if (led_q == ALL_ZERO) begin
              led_d = ALL_ONES;
            end else begin
              led_d = {1'b0, led_q[LED_W-1:1]};
            end
          end
          3'd4: begin
            // Turn around on reaching an end so each end is lit for one step.
            if (dir_q == DIR_DOWN) begin
              if (led_q[0]) begin
                dir_d = DIR_UP;
                led_d = {led_q[LED_W-2:0], 1'b0};
              end else begin
                led_d = {1'b0, led_q[LED_W-1:1]};
              end
            end else begin
              if (led_q[LED_W-1]) begin
                dir_d = DIR_DOWN;
                led_d = {1'b0, led_q[LED_W-1:1]};
              end else begin
                led_d = {led_q[LED_W-2:0], 1'b0};
              end
            end
          end
          3'd5: led_d = ~led_q;
          default: led_d = led_q;
        endcase
      end
    end else begin
      led_d  = led_q;
      dir_d  = dir_q;
      mode_d = mode_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      mode_q <= 3'd0;
      led_q  <= MSB_ONLY;
      dir_q  <= DIR_DOWN;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (LED_W=8, STEP_CYCLES=16).
// Expected frames are queued as each directed step is set up and popped
// when the DUT pulses step; step spacing is checked against a cycle count.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [7:0] led;
  logic       step;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ref_cyc  = 0;
  logic [7:0] exp_q[$];

  led_pattern_gen #(
    .LED_W(8),
    .STEP_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .speed(speed),
    .pause(pause),
    .led(led),
    .step(step)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to measure step spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  // Wait for n step pulses; check gap, frame and one-cycle pulse width.
  task automatic run_steps(input int n, input int first_gap, input int gap);
    int   waited;
    logic seen;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 200) begin
        @(negedge clk);
        waited++;
        if (step === 1'b1) seen = 1'b1;
      end
      check("step_seen", 32'(seen), 32'd1);
      check("step_gap", cyc - ref_cyc, (i == 0) ? first_gap : gap);
      ref_cyc = cyc;
      if (exp_q.size() > 0) begin
        check("led_frame", 32'(led), 32'(exp_q.pop_front()));
      end else begin
        n_assert++;
        n_fail++;
        $error("FAIL led_queue: observed step with led 0x%0h, expected no frame pending", led);
      end
      @(negedge clk);
      check("step_pulse", 32'(step), 32'd0);
    end
  endtask

  initial begin
    logic       stable;
    logic       seen;
    int         waited;

    rst   = 1'b1;
    mode  = 3'd0;
    speed = 2'd0;
    pause = 1'b0;
    #1;
    check("reset_led", 32'(led), 32'h80);
    check("reset_step", 32'(step), 32'd0);

    // Mode 0 rotate from reset.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ref_cyc = cyc;
    push(8'h40); push(8'h20); push(8'h10); push(8'h08);
    push(8'h04); push(8'h02); push(8'h01); push(8'h80);
    run_steps(8, 16, 16);

    // Mid-period change to blink: frame holds until the next tick.
    repeat (4) @(negedge clk);
    mode = 3'd5;
    @(negedge clk);
    check("mode_change_hold", 32'(led), 32'h80);
    push(8'hFF); push(8'h00); push(8'hFF);
    run_steps(3, 16, 16);

    // Freeze: frame held while step keeps pulsing.
    mode = 3'd6;
    push(8'hFF); push(8'hFF);
    run_steps(2, 16, 16);

    // Fill from LSB.
    mode = 3'd2;
    push(8'h00); push(8'h01); push(8'h03); push(8'h07); push(8'h0F);
    push(8'h1F); push(8'h3F); push(8'h7F); push(8'hFF); push(8'h00);
    run_steps(10, 16, 16);

    // Drain from MSB.
    mode = 3'd3;
    push(8'hFF); push(8'h7F); push(8'h3F); push(8'h1F); push(8'h0F);
    push(8'h07); push(8'h03); push(8'h01); push(8'h00); push(8'hFF);
    run_steps(10, 16, 16);

    // Bounce: each end lit for exactly one step.
    mode = 3'd4;
    push(8'h80); push(8'h40); push(8'h20); push(8'h10); push(8'h08); push(8'h04);
    push(8'h02); push(8'h01); push(8'h02); push(8'h04); push(8'h08); push(8'h10);
    push(8'h20); push(8'h40); push(8'h80); push(8'h40);
    run_steps(16, 16, 16);

    // Back to rotate, then speed 0->3 at cnt=10: tick next cycle, then every 2.
    mode = 3'd0;
    push(8'h80);
    run_steps(1, 16, 16);
    repeat (9) @(negedge clk);
    speed = 2'd3;
    push(8'h40); push(8'h20); push(8'h10); push(8'h08);
    run_steps(4, 11, 2);

    // Pause at cnt=5 for 20 cycles with a mode change queued behind it.
    speed = 2'd0;
    repeat (4) @(negedge clk);
    pause  = 1'b1;
    mode   = 3'd1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step !== 1'b0 || led !== 8'h08) stable = 1'b0;
    end
    check("pause_stable", 32'(stable), 32'd1);
    pause = 1'b0;
    push(8'h01); push(8'h02);
    run_steps(2, 36, 16);

    // Reset asserted between edges while step is high.
    mode = 3'd0;
    push(8'h80);
    run_steps(1, 16, 16);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 200) begin
      @(negedge clk);
      waited++;
      if (step === 1'b1) seen = 1'b1;
    end
    check("pre_reset_step", 32'(seen), 32'd1);
    check("pre_reset_led", 32'(led), 32'h40);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_led", 32'(led), 32'h80);
    check("async_reset_step", 32'(step), 32'd0);
    repeat (3) @(negedge clk);
    check("held_reset_led", 32'(led), 32'h80);
    rst = 1'b0;
    ref_cyc = cyc;
    push(8'h40);
    run_steps(1, 16, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine driving the board's LED bank from a single system clock. It generalises the fixed 8-LED, 4-mode flow-light to any LED count. It adds a bounce mode, a blink mode, a freeze mode, runtime speed selection and pause, and exposes a one-cycle step strobe for neighbouring blocks such as a buzzer or a segment display.

## Interface
- `LED_W`, default 8: number of LEDs, must be ≥2.
- `STEP_CYCLES`, default 6_000_000: base step period in clk cycles (0.5 s at 12 MHz), must be ≥16.
- `clk` in 1: system clock. One clock domain, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 3: pattern select. Encoding:
  - 0 rotate MSB→LSB
  - 1 rotate LSB→MSB
  - 2 fill from LSB
  - 3 drain from MSB
  - 4 bounce
  - 5 blink
  - 6/7 freeze
- `speed` in 2: step period = `STEP_CYCLES >> speed` (1×, 2×, 4×, 8× rate).
- `pause` in 1: high holds the counter. No steps occur while it is high.
- `led` out LED_W: LED drive, 1 = on, registered.
- `step` out 1: one-cycle pulse on every applied step, registered.

## Operation
- Period counter `cnt` is `$clog2(STEP_CYCLES)` bits wide. `P = STEP_CYCLES >> speed`.
- Tick condition is `!pause && cnt >= P-1`. On tick `cnt <= 0`. Otherwise, if `!pause`, `cnt <= cnt+1`.
- The `>=` comparison makes a speed change that shrinks `P` below the current `cnt` tick on the next cycle, with no long wrap.
- Register `mode_q` holds the mode applied at the last tick. All pattern updates happen only on a tick.
- On a tick with `mode != mode_q`, the block loads the initial pattern for the new mode and sets `mode_q <= mode`. This is the first frame of the new mode; no step is applied in that same tick. Initial patterns:
  - 0: MSB only
  - 1: LSB only
  - 2: all-zero
  - 3: all-ones
  - 4: MSB only, with `dir` set to down
  - 5: all-ones
  - 6/7: `led` unchanged (freeze keeps the current frame)
- On a tick with `mode == mode_q`, the block steps:
  - 0: `{led[0], led[W-1:1]}`
  - 1: `{led[W-2:0], led[W-1]}`
  - 2: if all-ones, load zero; else `{led[W-2:0], 1'b1}`
  - 3: if all-zero, load all-ones; else `{1'b0, led[W-1:1]}`
  - 4: if `dir` is down and `led[0]` is set, set `dir` up and shift left. Else if `dir` is down, shift right. If `dir` is up and `led[W-1]` is set, set `dir` down and shift right. Else if `dir` is up, shift left. End LEDs are therefore lit for exactly one step.
  - 5: `~led`
  - 6/7: hold.
- `step` is high for the one cycle after every tick, including mode-load ticks and freeze ticks.

## Timing
- Reset (async assert, value visible immediately): `led` = MSB only, `mode_q` = 0, `cnt` = 0, `dir` = down, `step` = 0.
- Reset release is synchronous in effect: the first tick occurs P cycles after the first clock edge with `rst` low.
- Latency: `led` and `step` update on the clock edge following the cycle in which the tick condition is true. There is no combinational path from inputs to outputs.
- A mode change is applied at the next tick, never mid-period. Changes that revert before that tick are ignored.
- A mode change while `pause` is high waits until ticking resumes.
- Pause mid-count freezes `cnt`. On release, counting resumes from the held value.
- Reset asserted mid-pattern overrides everything on the same cycle.
- `speed` is sampled every cycle and takes effect immediately on the tick comparison.

## Test plan
- LED_W=8, STEP_CYCLES=16, mode=0, speed=0, reset released → `led` shows 0x80, 0x40, 0x20 … 0x01, 0x80. Steps are 16 cycles apart and `step` pulses once per step.
- mode=4, LED_W=4 → first tick loads 1000, then 0100, 0010, 0001, 0010, 0100, 1000, 0100, with each end visited once per pass.
- mode=2 for 9 steps after load → 00000001 … 11111111, then 00000000. mode=3 → 01111111 … 00000000, then 11111111.
- speed switched 0→3 at cnt=10 → tick on the next cycle, after which steps occur every 2 cycles. pause high for 20 cycles → no `step`, `led` stable, and `cnt` resumes from its held value.
- Mode changed 0→5 at mid-period → `led` unchanged until the next tick, then 0xFF, then 0x00, 0xFF. Changing to 6 at the next tick freezes the current value while `step` keeps pulsing.
- `rst` asserted asynchronously between edges mid-pattern → `led`=0x80 and `step`=0 immediately. After release, the first step occurs 16 cycles later, in mode 0.
